// File: rtl/mem_stage_ctrl.sv
// Purpose : MEM-stage controller: issues EX/MEM loads/stores to a req/ack data memory, resolves branches, owns MEM/WB.
// Latency : combinational request/stall/redirect; MEM/WB and mem_err update on the edge that retires the instruction.
// Backpres: while the memory has not acked, stall holds the upstream pipe and MEM/WB receives a bubble.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_*_MEM                EX/MEM pipeline register fields (branch target, ALU result/address,
//                          zero flag, store data, destination register, control bits)
//   o_dm_req/o_dm_we       data-memory request and direction (1 = write)
//   o_dm_addr/o_dm_wdata   byte address and store data, straight from EX/MEM
//   i_dm_rdata/i_dm_ack    read data and completion strobe (ack may coincide with the request)
//   o_stall                hold PC, IF/ID, ID/EX and EX/MEM this cycle
//   o_pc_src/o_pc_target   fetch redirect for a taken branch
//   o_flush                clear IF/ID, ID/EX, EX/MEM (same as o_pc_src)
//   o_mem_err              one-cycle pulse after a misaligned access or a memory timeout
//   o_*_WB                 MEM/WB pipeline register
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc_branch_MEM,
  input  logic [31:0] i_alu_MEM,
  input  logic        i_zero_MEM,
  input  logic [31:0] i_writedata_MEM,
  input  logic [4:0]  i_rd_MEM,
  input  logic        i_branch_MEM,
  input  logic        i_memread_MEM,
  input  logic        i_memwrite_MEM,
  input  logic        i_memtoreg_MEM,
  input  logic        i_regwrite_MEM,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata,
  input  logic        i_dm_ack,
  output logic        o_stall,
  output logic        o_pc_src,
  output logic [31:0] o_pc_target,
  output logic        o_flush,
  output logic        o_mem_err,
  output logic [31:0] o_alu_WB,
  output logic [31:0] o_readdata_WB,
  output logic [4:0]  o_rd_WB,
  output logic        o_regwrite_WB,
  output logic        o_memtoreg_WB
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // MEM/WB register contents kept together as one packed word
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] readdata;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
  } memwb_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_nxt;
  memwb_t          r_memwb;
  logic            r_mem_err;

  logic            w_acc;
  logic            w_mis;
  logic            w_dm_req;
  logic            w_tmo;
  logic            w_stall;
  logic            w_rd_ack;

  assign w_acc = i_memread_MEM | i_memwrite_MEM;
  assign w_mis = w_acc & (i_alu_MEM[1:0] != 2'b00);

  // Next-state and request/timeout decode
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_dm_req       = 1'b0;
    w_tmo          = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Misaligned accesses never reach the memory
        w_dm_req = w_acc & ~w_mis;
        if (w_dm_req & ~i_dm_ack) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_dm_req = 1'b1;
        // An ack in the last allowed cycle still completes normally
        w_tmo    = ~i_dm_ack & (r_wait_cnt == LAST_CNT);
        if (i_dm_ack | w_tmo) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timeout releases the stall so the aborted instruction leaves EX/MEM this cycle
  assign w_stall  = w_dm_req & ~i_dm_ack & ~w_tmo;
  // Write wins when both control bits are set, so only a pure read captures data
  assign w_rd_ack = w_dm_req & i_dm_ack & i_memread_MEM & ~i_memwrite_MEM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memwb <= '0;
    end else if (w_stall) begin
      // Bubble into write-back; payload fields hold
      r_memwb.regwrite <= 1'b0;
      r_memwb.memtoreg <= 1'b0;
    end else begin
      r_memwb.alu      <= i_alu_MEM;
      r_memwb.rd       <= i_rd_MEM;
      r_memwb.memtoreg <= i_memtoreg_MEM;
      r_memwb.regwrite <= i_regwrite_MEM & ~w_mis & ~w_tmo;
      if (w_rd_ack) begin
        r_memwb.readdata <= i_dm_rdata;
      end
    end
  end

  // Reset during WAIT clears this too, so an aborted request reports nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_mis | w_tmo;
    end
  end

  assign o_dm_req      = w_dm_req;
  assign o_dm_we       = i_memwrite_MEM;
  assign o_dm_addr     = i_alu_MEM;
  assign o_dm_wdata    = i_writedata_MEM;
  assign o_stall       = w_stall;
  assign o_pc_src      = i_branch_MEM & i_zero_MEM & ~w_stall;
  assign o_flush       = o_pc_src;
  assign o_pc_target   = i_pc_branch_MEM;
  assign o_mem_err     = r_mem_err;
  assign o_alu_WB      = r_memwb.alu;
  assign o_readdata_WB = r_memwb.readdata;
  assign o_rd_WB       = r_memwb.rd;
  assign o_regwrite_WB = r_memwb.regwrite;
  assign o_memtoreg_WB = r_memwb.memtoreg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_branch, alu, wdata, dm_rdata;
  logic        zero, branch, memread, memwrite, memtoreg, regwrite, dm_ack;
  logic [4:0]  rd;
  logic        dm_req, dm_we, stall, pc_src, flush, mem_err;
  logic [31:0] dm_addr, dm_wdata, pc_target, alu_WB, readdata_WB;
  logic [4:0]  rd_WB;
  logic        regwrite_WB, memtoreg_WB;

  mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_pc_branch_MEM(pc_branch), .i_alu_MEM(alu), .i_zero_MEM(zero),
    .i_writedata_MEM(wdata), .i_rd_MEM(rd), .i_branch_MEM(branch),
    .i_memread_MEM(memread), .i_memwrite_MEM(memwrite),
    .i_memtoreg_MEM(memtoreg), .i_regwrite_MEM(regwrite),
    .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
    .i_dm_rdata(dm_rdata), .i_dm_ack(dm_ack),
    .o_stall(stall), .o_pc_src(pc_src), .o_pc_target(pc_target), .o_flush(flush),
    .o_mem_err(mem_err),
    .o_alu_WB(alu_WB), .o_readdata_WB(readdata_WB), .o_rd_WB(rd_WB),
    .o_regwrite_WB(regwrite_WB), .o_memtoreg_WB(memtoreg_WB)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected MEM/WB contents, updated once per retired instruction
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_rd;
  logic        m_rw, m_mtr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pc_branch = '0; alu = '0; wdata = '0; dm_rdata = '0; zero = 0; branch = 0;
    memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0; dm_ack = 0; rd = '0;
  endtask

  task automatic model_reset();
    m_alu = '0; m_rdata = '0; m_rd = '0; m_rw = 0; m_mtr = 0;
  endtask

  // One instruction through MEM; the memory acks after t_n wait cycles
  // (t_n beyond TMO means the memory never answers).
  task automatic run_instr(input logic t_br, input logic t_z, input logic t_mr, input logic t_mw,
                           input logic t_mtr, input logic t_rw, input logic [31:0] t_alu,
                           input logic [31:0] t_wd, input logic [31:0] t_pcb,
                           input logic [31:0] t_rdat, input logic [4:0] t_rd, input int t_n);
    bit acc, mis, tmo, acked, done;
    int exp_req, exp_stall, req_cnt, st_cnt, cyc;
    logic exp_pc;
    logic [31:0] junk;
    acc = t_mr | t_mw;
    mis = acc && (t_alu % 4 != 0);
    tmo = 0; acked = 0;
    if (!acc || mis) begin
      exp_req = 0; exp_stall = 0;
    end else if (t_n <= TMO) begin
      exp_req = t_n + 1; exp_stall = t_n; acked = 1;
    end else begin
      exp_req = TMO + 1; exp_stall = TMO; tmo = 1;
    end

    @(negedge clk);
    branch = t_br; zero = t_z; memread = t_mr; memwrite = t_mw; memtoreg = t_mtr;
    regwrite = t_rw; alu = t_alu; wdata = t_wd; pc_branch = t_pcb; rd = t_rd;
    req_cnt = 0; st_cnt = 0; cyc = 0; done = 0;
    while (!done) begin
      junk     = $urandom();
      dm_ack   = (exp_req > 0) && (cyc == t_n);
      dm_rdata = (cyc == t_n) ? t_rdat : junk;
      #1;
      if (dm_req) begin
        req_cnt++;
        chk("dm_we", dm_we, t_mw);
        chk("dm_addr", dm_addr, t_alu);
        chk("dm_wdata", dm_wdata, t_wd);
      end
      if (stall) st_cnt++;
      exp_pc = (cyc == exp_stall) && t_br && t_z;
      chk("pc_src", pc_src, exp_pc);
      chk("flush", flush, exp_pc);
      chk("pc_target", pc_target, t_pcb);
      done = !stall || (cyc >= TMO + 1);
      @(posedge clk); #1;
      if (!done) begin
        chk("bubble_regwrite", regwrite_WB, 1'b0);
        chk("bubble_memtoreg", memtoreg_WB, 1'b0);
        chk("bubble_mem_err", mem_err, 1'b0);
        chk("hold_alu_WB", alu_WB, m_alu);
        @(negedge clk);
      end else begin
        m_alu = t_alu; m_rd = t_rd; m_mtr = t_mtr;
        m_rw  = t_rw && !mis && !tmo;
        if (acked && t_mr && !t_mw) m_rdata = t_rdat;
        chk("alu_WB", alu_WB, m_alu);
        chk("rd_WB", rd_WB, m_rd);
        chk("memtoreg_WB", memtoreg_WB, m_mtr);
        chk("regwrite_WB", regwrite_WB, m_rw);
        chk("readdata_WB", readdata_WB, m_rdata);
        chk("mem_err", mem_err, mis || tmo);
      end
      cyc++;
    end
    chk("req_cycles", req_cnt, exp_req);
    chk("stall_cycles", st_cnt, exp_stall);
    dm_ack = 0;
  endtask

  initial begin
    logic [31:0] r_alu, r_wd, r_pcb, r_rdat, r_ctl;
    clear_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_alu_WB", alu_WB, 32'h0);
    chk("rst_readdata_WB", readdata_WB, 32'h0);
    chk("rst_rd_WB", rd_WB, 5'd0);
    chk("rst_regwrite_WB", regwrite_WB, 1'b0);
    chk("rst_memtoreg_WB", memtoreg_WB, 1'b0);
    @(negedge clk);
    rst = 0;

    // Zero-wait load
    run_instr(0, 0, 1, 0, 1, 1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 0);
    // 3-wait store
    run_instr(0, 0, 0, 1, 0, 0, 32'h200, 32'h1234, 32'h0, 32'h0, 5'd3, 3);
    // Load never acked: timeout
    run_instr(0, 0, 1, 0, 1, 1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd7, 1000);
    // Misaligned load
    run_instr(0, 0, 1, 0, 1, 1, 32'h102, 32'h0, 32'h0, 32'h55, 5'd9, 0);
    // Branch taken / not taken
    run_instr(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h40, 32'h0, 5'd0, 0);
    run_instr(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h40, 32'h0, 5'd0, 0);
    // Ack in the last allowed wait cycle
    run_instr(0, 0, 1, 0, 1, 1, 32'h404, 32'h0, 32'h0, 32'hCAFE0001, 5'd12, TMO);
    // Read and write both set: write wins, readdata holds
    run_instr(0, 0, 1, 1, 0, 1, 32'h508, 32'h77, 32'h0, 32'hBAD0BAD0, 5'd13, 1);

    // Reset while in the second WAIT cycle
    @(negedge clk);
    memread = 1; regwrite = 1; memtoreg = 1; alu = 32'h600; rd = 5'd4; dm_ack = 0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("wait1_stall", stall, 1'b1);
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    chk("rstw_dm_req", dm_req, 1'b0);
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_mem_err", mem_err, 1'b0);
    chk("rstw_alu_WB", alu_WB, 32'h0);
    chk("rstw_readdata_WB", readdata_WB, 32'h0);
    chk("rstw_rd_WB", rd_WB, 5'd0);
    chk("rstw_regwrite_WB", regwrite_WB, 1'b0);
    chk("rstw_memtoreg_WB", memtoreg_WB, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_mem_err", mem_err, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      r_alu  = $urandom();
      r_wd   = $urandom();
      r_pcb  = $urandom();
      r_rdat = $urandom();
      r_ctl  = $urandom();
      if ($urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
      run_instr(r_ctl[0], r_ctl[1], r_ctl[2], r_ctl[3], r_ctl[4], r_ctl[5],
                r_alu, r_wd, r_pcb, r_rdat, r_ctl[10:6], int'($urandom_range(0, TMO + 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
